// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready input and output handshake. Shifts run
// one bit per clock in the SHIFT state; every other op completes in one edge.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] alu_a_in,
  input  logic [WIDTH-1:0] alu_b_in,
  input  logic [3:0]       alu_select,
  input  logic             alu_in_valid,
  output logic             alu_in_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_carry_out,
  output logic             alu_zero_flag,
  output logic             alu_out_valid,
  input  logic             alu_out_ready,
  output logic             dbg_state_o
);

  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_ADDC = 4'b0101;
  localparam logic [3:0] OP_SUBB = 4'b0110;
  localparam logic [3:0] OP_SHFR = 4'b1011;
  localparam logic [3:0] OP_SHFL = 4'b1100;

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  // Handshake: a transfer happens on a rising edge where valid && ready on
  // that side; a producer holds valid and its data until the transfer edge.
  state_t               state_q, state_d;
  logic [WIDTH-1:0]     sh_q, sh_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic                 dir_left_q, dir_left_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 carry_q, carry_d;
  logic                 zero_q, zero_d;
  logic                 valid_q, valid_d;
  logic                 cflag_q, cflag_d;

  logic                 accept;
  logic                 is_shift;
  logic [SHAMT_W-1:0]   shamt;
  logic                 start_shift;
  logic                 write_imm;
  logic                 shift_done;
  logic [WIDTH-1:0]     sh_next;

  logic [WIDTH:0]       a_x, b_x, cin_x, ext;
  logic [WIDTH-1:0]     res_o;
  logic                 res_c, res_z, upd_cflag;

  assign accept      = alu_in_valid && alu_in_ready;
  assign shamt       = alu_b_in[SHAMT_W-1:0];
  assign is_shift    = (alu_select == OP_SHFL) || (alu_select == OP_SHFR);
  assign start_shift = accept && is_shift && (shamt != '0);
  assign write_imm   = accept && !start_shift;
  assign shift_done  = (state_q == S_SHIFT) && (cnt_q == SHAMT_W'(1));
  assign sh_next     = dir_left_q ? (sh_q << 1) : (sh_q >> 1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_shift) state_d = S_SHIFT;
      S_SHIFT: if (shift_done)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    alu_in_ready  = (state_q == S_IDLE) && (!valid_q || alu_out_ready);
    alu_out       = out_q;
    alu_carry_out = carry_q;
    alu_zero_flag = zero_q;
    alu_out_valid = valid_q;
    dbg_state_o   = state_q;
  end

  // Single-cycle results; carry is the borrow bit for subtractions.
  always_comb begin
    a_x       = {1'b0, alu_a_in};
    b_x       = {1'b0, alu_b_in};
    cin_x     = {{WIDTH{1'b0}}, cflag_q};
    ext       = '0;
    res_c     = 1'b0;
    res_z     = 1'b0;
    upd_cflag = 1'b0;
    case (alu_select)
      OP_ADD:  begin ext = a_x + b_x;         upd_cflag = 1'b1; end
      OP_SUB:  begin ext = a_x - b_x;         upd_cflag = 1'b1; end
      OP_ADDC: begin ext = a_x + b_x + cin_x; upd_cflag = 1'b1; end
      OP_SUBB: begin ext = a_x - b_x - cin_x; upd_cflag = 1'b1; end
      OP_NOR:  ext = {1'b0, ~(alu_a_in | alu_b_in)};
      OP_SHFL, OP_SHFR: ext = a_x;
      default: ext = '0;
    endcase
    res_o = ext[WIDTH-1:0];
    if (upd_cflag) res_c = ext[WIDTH];
    if (alu_select != OP_NOP && (upd_cflag || alu_select == OP_NOR || is_shift))
      res_z = (res_o == '0);
  end

  always_comb begin
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    dir_left_d = dir_left_q;
    if (start_shift) begin
      sh_d       = alu_a_in;
      cnt_d      = shamt;
      dir_left_d = (alu_select == OP_SHFL);
    end else if (state_q == S_SHIFT) begin
      sh_d  = sh_next;
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Result registers only move on a write, so they hold under back-pressure.
  always_comb begin
    out_d   = out_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    cflag_d = cflag_q;
    valid_d = valid_q;
    if (valid_q && alu_out_ready) valid_d = 1'b0;
    if (write_imm) begin
      out_d   = res_o;
      carry_d = res_c;
      zero_d  = res_z;
      valid_d = 1'b1;
      if (upd_cflag) cflag_d = res_c;
    end else if (shift_done) begin
      out_d   = sh_next;
      carry_d = dir_left_q & sh_q[WIDTH-1];
      zero_d  = (sh_next == '0);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q       <= '0;
      cnt_q      <= '0;
      dir_left_q <= 1'b0;
      out_q      <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      valid_q    <= 1'b0;
      cflag_q    <= 1'b0;
    end else begin
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      dir_left_q <= dir_left_d;
      out_q      <= out_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      valid_q    <= valid_d;
      cflag_q    <= cflag_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: WIDTH=8 instance with an expected-result queue,
// plus a WIDTH=16 instance for the wide-operand vectors.
module tb_alu_seq;

  localparam int W  = 8;
  localparam int W2 = 16;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_ADDC = 4'b0101;
  localparam logic [3:0] OP_SUBB = 4'b0110;
  localparam logic [3:0] OP_SHFR = 4'b1011;
  localparam logic [3:0] OP_SHFL = 4'b1100;
  localparam logic [3:0] OP_RSVD = 4'b1111;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [W-1:0]  a8, b8, o8;
  logic [3:0]    sel8;
  logic          iv8, ir8, ov8, or8, c8, z8, st8;

  logic [W2-1:0] a16, b16, o16;
  logic [3:0]    sel16;
  logic          iv16, ir16, ov16, or16, c16, z16, st16;

  alu_seq #(.WIDTH(W)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .alu_a_in(a8), .alu_b_in(b8), .alu_select(sel8),
    .alu_in_valid(iv8), .alu_in_ready(ir8),
    .alu_out(o8), .alu_carry_out(c8), .alu_zero_flag(z8),
    .alu_out_valid(ov8), .alu_out_ready(or8),
    .dbg_state_o(st8)
  );

  alu_seq #(.WIDTH(W2)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .alu_a_in(a16), .alu_b_in(b16), .alu_select(sel16),
    .alu_in_valid(iv16), .alu_in_ready(ir16),
    .alu_out(o16), .alu_carry_out(c16), .alu_zero_flag(z16),
    .alu_out_valid(ov16), .alu_out_ready(or16),
    .dbg_state_o(st16)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W+1:0] exp_q[$];   // {carry, zero, out}
  string        tag_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [W+1:0] mon_e;
  string        mon_t;
  always @(negedge clk) begin
    if (rst_n && ov8 && or8) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {c8, z8, o8}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = tag_q.pop_front();
        check(mon_t, {c8, z8, o8}, mon_e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue8(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag, input logic ec, input logic ez,
                        input logic [W-1:0] eo, input bit push);
    bit ok = 0;
    if (push) begin
      exp_q.push_back({ec, ez, eo});
      tag_q.push_back(tag);
    end
    a8 = a; b8 = b; sel8 = op; iv8 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ir8) begin ok = 1; break; end
    end
    if (!ok) check({tag, "_ready_timeout"}, 0, 1);
    @(posedge clk); #1;
    iv8 = 1'b0;
    a8 = W'($urandom); b8 = W'($urandom); sel8 = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
      tag_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic run16(input logic [3:0] op, input logic [W2-1:0] a, input logic [W2-1:0] b,
                       input string tag, input logic [W2+1:0] exp);
    bit got = 0;
    a16 = a; b16 = b; sel16 = op; iv16 = 1'b1;
    @(negedge clk);
    check({tag, "_ready"}, ir16, 1);
    @(posedge clk); #1;
    iv16 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ov16) begin got = 1; break; end
    end
    check({tag, "_done"}, got, 1);
    check(tag, {c16, z16, o16}, exp);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  int   c0, t0, low, lat;
  bit   seen;
  logic [W+1:0] snap;

  initial begin
    a8 = '0; b8 = '0; sel8 = OP_NOP; iv8 = 1'b0; or8 = 1'b1;
    a16 = '0; b16 = '0; sel16 = OP_NOP; iv16 = 1'b0; or16 = 1'b1;

    repeat (2) @(posedge clk);
    #2;
    check("rst_out",   o8,  0);
    check("rst_carry", c8,  0);
    check("rst_zero",  z8,  0);
    check("rst_valid", ov8, 0);
    check("rst_state", st8, 0);
    check("rst_valid16", ov16, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", ir8, 1);
    @(posedge clk); #1;

    // basic ops and flags
    issue8(OP_ADD,  8'hFF, 8'h02, "add_ovf",    1'b1, 1'b0, 8'h01, 1);
    c0 = cyc;
    @(negedge clk);
    check("add_latency1", ov8, 1);
    @(posedge clk); #1;
    issue8(OP_SUB,  8'h0F, 8'hFF, "sub_borrow", 1'b1, 1'b0, 8'h10, 1);
    issue8(OP_NOR,  8'hFF, 8'hFF, "nor_zero",   1'b0, 1'b1, 8'h00, 1);
    issue8(OP_NOR,  8'h0F, 8'h30, "nor_val",    1'b0, 1'b0, 8'hC0, 1);
    issue8(OP_NOP,  8'h12, 8'h34, "nop",        1'b0, 1'b0, 8'h00, 1);
    issue8(OP_RSVD, 8'h55, 8'hAA, "reserved",   1'b0, 1'b0, 8'h00, 1);

    // carry chain through cflag
    issue8(OP_ADD,  8'hFF, 8'h01, "add_wrap",   1'b1, 1'b1, 8'h00, 1);
    issue8(OP_ADDC, 8'h00, 8'h00, "addc_cin1",  1'b0, 1'b0, 8'h01, 1);
    issue8(OP_SUBB, 8'h05, 8'h01, "subb_cin0",  1'b0, 1'b0, 8'h04, 1);
    issue8(OP_ADD,  8'h80, 8'h80, "add_8080",   1'b1, 1'b1, 8'h00, 1);
    issue8(OP_SUBB, 8'h00, 8'h00, "subb_cin1",  1'b1, 1'b0, 8'hFF, 1);
    issue8(OP_NOR,  8'h00, 8'h00, "nor_keepcf", 1'b0, 1'b0, 8'hFF, 1);
    issue8(OP_ADDC, 8'h01, 8'h01, "addc_after_nor", 1'b0, 1'b0, 8'h03, 1);

    // shifts
    issue8(OP_SHFR, 8'hFF, 8'h01, "shfr1",      1'b0, 1'b0, 8'h7F, 1);
    issue8(OP_SHFL, 8'h81, 8'h00, "shfl0",      1'b0, 1'b0, 8'h81, 1);
    issue8(OP_SHFR, 8'h3C, 8'h08, "shfr_amt_bits", 1'b0, 1'b0, 8'h3C, 1);
    issue8(OP_SHFL, 8'h80, 8'h01, "shfl_out1",  1'b1, 1'b1, 8'h00, 1);
    wait_drain();

    issue8(OP_SHFL, 8'h2D, 8'h03, "shfl3",      1'b1, 1'b0, 8'h68, 1);
    c0 = cyc; low = 0; seen = 0; lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!ir8) low++;
      if (ov8) begin lat = cyc - c0 + 1; seen = 1; break; end
    end
    check("shfl3_seen", seen, 1);
    check("shfl3_latency", lat, 4);
    check("shfl3_ready_low", low, 3);
    wait_drain();

    // back-pressure: outputs frozen, inputs ignored while not ready
    or8 = 1'b0;
    issue8(OP_ADD, 8'h10, 8'h20, "bp_add", 1'b0, 1'b0, 8'h30, 1);
    @(negedge clk);
    snap = {c8, z8, o8};
    check("bp_snap", snap, {1'b0, 1'b0, 8'h30});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      a8 = W'($urandom); b8 = W'($urandom); sel8 = 4'($urandom_range(0, 15)); iv8 = 1'b1;
      @(negedge clk);
      check("bp_hold_out",   {c8, z8, o8}, snap);
      check("bp_hold_valid", ov8, 1);
      check("bp_hold_ready", ir8, 0);
    end
    @(posedge clk); #1;
    iv8 = 1'b0; or8 = 1'b1;
    t0 = cyc;
    issue8(OP_ADD, 8'h01, 8'h01, "b2b_0", 1'b0, 1'b0, 8'h02, 1);
    issue8(OP_ADD, 8'hFE, 8'h01, "b2b_1", 1'b0, 1'b0, 8'hFF, 1);
    issue8(OP_ADD, 8'h7F, 8'h81, "b2b_2", 1'b1, 1'b1, 8'h00, 1);
    issue8(OP_ADD, 8'h40, 8'h40, "b2b_3", 1'b0, 1'b0, 8'h80, 1);
    check("b2b_cycles", cyc - t0, 4);
    wait_drain();

    // reset in the middle of a long shift
    issue8(OP_ADD,  8'hFF, 8'h01, "pre_abort_add", 1'b1, 1'b1, 8'h00, 1);
    issue8(OP_SHFL, 8'h81, 8'h07, "aborted", 1'b0, 1'b0, 8'h00, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_state", st8, 0);
    check("abort_valid", ov8, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov8) seen = 1;
    end
    check("abort_no_valid", seen, 0);
    @(posedge clk); #1;
    issue8(OP_ADDC, 8'h00, 8'h00, "addc_after_abort", 1'b0, 1'b1, 8'h00, 1);
    wait_drain();

    // wide instance
    run16(OP_SUB,  16'h0001, 16'h0002, "w16_sub",   {1'b1, 1'b0, 16'hFFFF});
    run16(OP_SHFL, 16'h8001, 16'h000F, "w16_shfl15", {1'b0, 1'b0, 16'h8000});

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the operand and result width; legal values are 4..64.
REQ-002 The block SHALL derive localparam SHAMT_W = clog2(WIDTH), the shift-amount width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port alu_a_in, input, WIDTH bits: operand A.
REQ-006 The block SHALL have port alu_b_in, input, WIDTH bits: operand B, whose bits [SHAMT_W-1:0] are the shift amount for shift ops.
REQ-007 The block SHALL have port alu_select, input, 4 bits: the opcode.
REQ-008 The block SHALL have port alu_in_valid, input, 1 bit: the operands and opcode are valid.
REQ-009 The block SHALL have port alu_in_ready, output, 1 bit: the block can accept an operation.
REQ-010 The block SHALL have port alu_out, output, WIDTH bits: the registered result.
REQ-011 The block SHALL have port alu_carry_out, output, 1 bit: the registered carry/borrow.
REQ-012 The block SHALL have port alu_zero_flag, output, 1 bit: the registered zero flag.
REQ-013 The block SHALL have port alu_out_valid, output, 1 bit: the result is valid.
REQ-014 The block SHALL have port alu_out_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-015 Opcodes SHALL be: NOP 0000, ADD 0001, SUB 0010, NOR 0011, ADDC 0101, SUBB 0110, SHFR 1011, SHFL 1100; all others are reserved.
REQ-016 An operation SHALL be accepted on a rising edge where alu_in_valid && alu_in_ready; inputs are sampled only at that edge.
REQ-017 alu_in_ready SHALL equal (state==IDLE) && (!alu_out_valid || alu_out_ready).
REQ-018 The FSM SHALL have states IDLE and SHIFT; at most one operation SHALL be in flight.
REQ-019 A non-shift op, or a shift with amount 0, SHALL write its result at the accept edge, so alu_out_valid is high from the next cycle (latency 1), and the FSM SHALL stay in IDLE.
REQ-020 A shift with amount n>=1 SHALL load A and n at the accept edge, move to SHIFT, shift one bit per edge, and write the result and return to IDLE on the nth edge after acceptance (latency n+1).
REQ-021 ADD SHALL compute {carry,out} = A+B.
REQ-022 SUB SHALL compute out = A-B, with carry = borrow (A<B).
REQ-023 NOR SHALL compute out = ~(A|B), with carry 0.
REQ-024 ADDC SHALL compute A+B+cflag, with carry as for ADD.
REQ-025 SUBB SHALL compute A-B-cflag, with carry = borrow.
REQ-026 SHFL SHALL compute out = A<<n with zero fill, and carry = the last bit shifted out (A[WIDTH-n]), or 0 when n=0.
REQ-027 SHFR SHALL compute out = A>>n with zero fill, and carry = 0.
REQ-028 All arithmetic SHALL be modulo 2^WIDTH.
REQ-029 alu_zero_flag SHALL be (out==0) for ADD, SUB, NOR, ADDC, SUBB, SHFL and SHFR.
REQ-030 NOP and reserved opcodes SHALL complete with latency 1 and produce out=0, carry=0, zero=0.
REQ-031 cflag SHALL be an internal register loaded with the carry of each completed ADD, ADDC, SUB or SUBB, and left unchanged by all other ops.
REQ-032 While alu_out_valid && !alu_out_ready, alu_out, alu_carry_out and alu_zero_flag SHALL hold stable.
REQ-033 alu_out_valid SHALL fall after an edge with alu_out_ready high, unless a new result is written at that same edge.
REQ-034 Simultaneous output accept and input accept SHALL be legal, giving a throughput of one non-shift op per cycle.
REQ-035 Opcode or operand changes while alu_in_ready is low SHALL have no effect.

Reset
REQ-036 On rst_n low, regardless of the clock, the block SHALL immediately set state=IDLE, alu_out=0, alu_carry_out=0, alu_zero_flag=0, alu_out_valid=0, cflag=0, and clear the shift counter.
REQ-037 A reset asserted mid-shift SHALL abort the operation with no result produced.
REQ-038 After reset release, alu_in_ready SHALL be 1 at the first clock edge.

Verification
REQ-039 With WIDTH=8: ADD 0xFF+0x02 -> out 0x01, carry 1, zero 0; SUB 0x0F-0xFF -> out 0x10, carry 1; NOR 0xFF,0xFF -> out 0x00, zero 1; NOP -> all outputs 0.
REQ-040 ADD 0xFF+0x01 -> out 0x00, carry 1, zero 1; the following ADDC 0x00+0x00 -> out 0x01, carry 0; the following SUBB 0x05-0x01 -> out 0x04.
REQ-041 SHFL A=0x2D with B=3 -> out 0x68, carry 1, alu_out_valid rising 4 cycles after acceptance, and alu_in_ready low for 3 cycles; SHFR A=0xFF with B=1 -> out 0x7F, carry 0.
REQ-042 Back-pressure: with alu_out_ready held low for 5 cycles after a result, outputs stay stable and alu_in_ready stays low; on release, a back-to-back ADD stream completes one op per cycle.
REQ-043 Asserting rst_n low in cycle 2 of SHFL with B=7 -> alu_out_valid never rises and cflag is 0 (verified by a subsequent ADDC 0+0 -> 0x00, zero 1).
REQ-044 With WIDTH=16: SUB 0x0001-0x0002 -> out 0xFFFF, carry 1; SHFL A=0x8001 with B=15 -> out 0x8000, carry 0.
